// File: rtl/rtv_pkg.sv
// rtl/rtv_pkg.sv - shared types, constants and request validation for the booking dispatcher
package rtv_pkg;

  localparam int CTR_W = 2;

  localparam logic [2:0] LAST_STN_T0 = 3'd4;
  localparam logic [2:0] LAST_STN_T1 = 3'd3;
  localparam logic [3:0] MAX_TICKETS = 4'd10;

  typedef enum logic [1:0] {
    ST_OK       = 2'b00,
    ST_NO_SEATS = 2'b01,
    ST_INVALID  = 2'b10
  } rsp_status_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } disp_state_e;

  typedef struct packed {
    logic [CTR_W-1:0] ctr;
    logic             train;
    logic [2:0]       src;
    logic [2:0]       dest;
    logic [3:0]       tickets;
  } req_entry_t;

  localparam int REQ_ENTRY_W = $bits(req_entry_t);

  // Each train serves a different number of stations; travel is only forward.
  function automatic logic req_is_valid(input req_entry_t r);
    logic [2:0] last_stn;
    last_stn = r.train ? LAST_STN_T1 : LAST_STN_T0;
    return (r.src < r.dest) && (r.tickets != 4'd0) &&
           (r.tickets <= MAX_TICKETS) && (r.dest <= last_stn);
  endfunction

endpackage

// File: rtl/rtv_req_fifo.sv
// rtl/rtv_req_fifo.sv - synchronous request FIFO with full/empty flags
module rtv_req_fifo #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/rtv_booking_dispatcher.sv
// rtl/rtv_booking_dispatcher.sv - round-robin counter arbiter, request validator and engine sequencer
module rtv_booking_dispatcher
  import rtv_pkg::*;
#(
  parameter int NUM_CTR    = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int RESP_LAT   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_CTR-1:0]   req_valid_i,
  output logic [NUM_CTR-1:0]   req_ready_o,
  input  logic [NUM_CTR-1:0]   req_train_id_i,
  input  logic [3*NUM_CTR-1:0] req_src_i,
  input  logic [3*NUM_CTR-1:0] req_dest_i,
  input  logic [4*NUM_CTR-1:0] req_tickets_i,
  output logic                 eng_book_req_o,
  output logic                 eng_train_id_o,
  output logic [2:0]           eng_src_o,
  output logic [2:0]           eng_dest_o,
  output logic [3:0]           eng_num_tickets_o,
  input  logic                 eng_success_i,
  input  logic [3:0]           eng_booked_count_i,
  input  logic [15:0]          eng_total_fare_i,
  output logic                 rsp_valid_o,
  output logic [1:0]           rsp_ctr_o,
  output logic [1:0]           rsp_status_o,
  output logic [3:0]           rsp_count_o,
  output logic [15:0]          rsp_total_fare_o,
  output logic [7:0]           stat_served_o,
  output logic [7:0]           stat_rejected_o
);

  localparam int CNT_W = $clog2(RESP_LAT + 1);

  logic [CTR_W-1:0]   rr_q, rr_d, grant_idx;
  logic [NUM_CTR-1:0] grant;
  logic               grant_any, accept;
  req_entry_t         push_entry;

  logic                   fifo_pop, fifo_full, fifo_empty;
  logic [REQ_ENTRY_W-1:0] fifo_rdata;

  disp_state_e      state_q, state_d;
  req_entry_t       cur_q, cur_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  rsp_status_e      res_status_q, res_status_d;
  logic [3:0]       res_count_q, res_count_d;
  logic [15:0]      res_fare_q, res_fare_d;
  logic [7:0]       served_q, served_d;
  logic [7:0]       rejected_q, rejected_d;
  logic             in_resp, eng_active;

  always_comb begin
    int idx;
    idx        = 0;
    grant      = '0;
    grant_idx  = '0;
    grant_any  = 1'b0;
    for (int k = 0; k < NUM_CTR; k++) begin
      idx = (int'(rr_q) + k) % NUM_CTR;
      if (!grant_any && req_valid_i[idx]) begin
        grant_any      = 1'b1;
        grant[idx]     = 1'b1;
        grant_idx      = CTR_W'(idx);
      end
    end
  end

  assign req_ready_o = fifo_full ? '0 : grant;
  assign accept      = grant_any && !fifo_full;

  always_comb begin
    rr_d = rr_q;
    if (accept) rr_d = (grant_idx == CTR_W'(NUM_CTR - 1)) ? '0 : grant_idx + CTR_W'(1);
  end

  always_comb begin
    push_entry     = '0;
    push_entry.ctr = grant_idx;
    for (int i = 0; i < NUM_CTR; i++) begin
      if (grant[i]) begin
        push_entry.train   = req_train_id_i[i];
        push_entry.src     = req_src_i[3*i +: 3];
        push_entry.dest    = req_dest_i[3*i +: 3];
        push_entry.tickets = req_tickets_i[4*i +: 4];
      end
    end
  end

  rtv_req_fifo #(
    .WIDTH (REQ_ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (accept),
    .wdata_i (push_entry),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d      = state_q;
    cur_d        = cur_q;
    cnt_d        = cnt_q;
    res_status_d = res_status_q;
    res_count_d  = res_count_q;
    res_fare_d   = res_fare_q;
    served_d     = served_q;
    rejected_d   = rejected_q;
    fifo_pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          cur_d    = fifo_rdata;
          state_d  = S_CHECK;
        end
      end
      S_CHECK: begin
        if (req_is_valid(cur_q)) begin
          state_d = S_ISSUE;
        end else begin
          res_status_d = ST_INVALID;
          res_count_d  = '0;
          res_fare_d   = '0;
          state_d      = S_RESP;
        end
      end
      S_ISSUE: begin
        cnt_d   = CNT_W'(1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == CNT_W'(RESP_LAT)) begin
          if (eng_success_i) begin
            res_status_d = ST_OK;
            res_count_d  = eng_booked_count_i;
            res_fare_d   = eng_total_fare_i;
          end else begin
            res_status_d = ST_NO_SEATS;
            res_count_d  = '0;
            res_fare_d   = '0;
          end
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP: begin
        if (res_status_q == ST_OK) begin
          if (served_q != 8'hff) served_d = served_q + 8'd1;
        end else begin
          if (rejected_q != 8'hff) rejected_d = rejected_q + 8'd1;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q         <= '0;
      state_q      <= S_IDLE;
      cur_q        <= '0;
      cnt_q        <= '0;
      res_status_q <= ST_OK;
      res_count_q  <= '0;
      res_fare_q   <= '0;
      served_q     <= '0;
      rejected_q   <= '0;
    end else begin
      rr_q         <= rr_d;
      state_q      <= state_d;
      cur_q        <= cur_d;
      cnt_q        <= cnt_d;
      res_status_q <= res_status_d;
      res_count_q  <= res_count_d;
      res_fare_q   <= res_fare_d;
      served_q     <= served_d;
      rejected_q   <= rejected_d;
    end
  end

  // Operands are exposed only while the engine owns the request, so reset
  // or an invalid request never leaves stale values on the engine bus.
  assign in_resp    = (state_q == S_RESP);
  assign eng_active = (state_q == S_ISSUE) || (state_q == S_WAIT) ||
                      (in_resp && res_status_q != ST_INVALID);

  assign eng_book_req_o    = (state_q == S_ISSUE);
  assign eng_train_id_o    = eng_active && cur_q.train;
  assign eng_src_o         = eng_active ? cur_q.src     : '0;
  assign eng_dest_o        = eng_active ? cur_q.dest    : '0;
  assign eng_num_tickets_o = eng_active ? cur_q.tickets : '0;

  assign rsp_valid_o      = in_resp;
  assign rsp_ctr_o        = in_resp ? cur_q.ctr    : '0;
  assign rsp_status_o     = in_resp ? res_status_q : ST_OK;
  assign rsp_count_o      = in_resp ? res_count_q  : '0;
  assign rsp_total_fare_o = in_resp ? res_fare_q   : '0;
  assign stat_served_o    = served_q;
  assign stat_rejected_o  = rejected_q;

endmodule

// File: tb/tb_rtv_booking_dispatcher.sv
// tb/tb_rtv_booking_dispatcher.sv - scoreboard bench for the booking dispatcher
module tb_rtv_booking_dispatcher;

  localparam int NUM_CTR    = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int RESP_LAT   = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_ready, req_train_id;
  logic [5:0]  req_src, req_dest;
  logic [7:0]  req_tickets;
  logic        eng_book_req, eng_train_id;
  logic [2:0]  eng_src, eng_dest;
  logic [3:0]  eng_num_tickets;
  logic        eng_success;
  logic [3:0]  eng_booked_count;
  logic [15:0] eng_total_fare;
  logic        rsp_valid;
  logic [1:0]  rsp_ctr, rsp_status;
  logic [3:0]  rsp_count;
  logic [15:0] rsp_total_fare;
  logic [7:0]  stat_served, stat_rejected;

  always #5 clk = ~clk;

  rtv_booking_dispatcher #(
    .NUM_CTR(NUM_CTR), .FIFO_DEPTH(FIFO_DEPTH), .RESP_LAT(RESP_LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_train_id_i(req_train_id),
    .req_src_i(req_src), .req_dest_i(req_dest), .req_tickets_i(req_tickets),
    .eng_book_req_o(eng_book_req), .eng_train_id_o(eng_train_id), .eng_src_o(eng_src),
    .eng_dest_o(eng_dest), .eng_num_tickets_o(eng_num_tickets),
    .eng_success_i(eng_success), .eng_booked_count_i(eng_booked_count),
    .eng_total_fare_i(eng_total_fare),
    .rsp_valid_o(rsp_valid), .rsp_ctr_o(rsp_ctr), .rsp_status_o(rsp_status),
    .rsp_count_o(rsp_count), .rsp_total_fare_o(rsp_total_fare),
    .stat_served_o(stat_served), .stat_rejected_o(stat_rejected)
  );

  typedef struct packed {
    logic       train;
    logic [2:0] src;
    logic [2:0] dest;
    logic [3:0] tkt;
  } tb_req_t;

  typedef struct packed {
    logic [1:0]  ctr;
    logic [1:0]  status;
    logic [3:0]  count;
    logic [15:0] fare;
  } tb_rsp_t;

  tb_req_t pend0[$];
  tb_req_t pend1[$];
  tb_req_t book_q[$];
  tb_rsp_t sb[$];
  int      acc_log[$];

  int n_vec = 0, n_err = 0, cyc = 0;
  int n_acc = 0, n_book = 0, n_rsp = 0, n_stall = 0;
  int last_acc_cyc = 0, last_book_cyc = 0, prev_book_cyc = 0, last_rsp_cyc = 0;
  int eng_since = 1000;
  logic    prev_book = 1'b0;
  tb_req_t eng_op;
  tb_req_t mon_b;
  tb_rsp_t mon_e;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic tb_req_t mk(input logic t, input logic [2:0] s, input logic [2:0] d,
                                 input logic [3:0] n);
    return {t, s, d, n};
  endfunction

  function automatic bit model_ok(input tb_req_t r);
    int last_stn;
    last_stn = r.train ? 3 : 4;
    return (r.src < r.dest) && (r.tkt >= 1) && (r.tkt <= 10) && (int'(r.dest) <= last_stn);
  endfunction

  function automatic bit eng_succ(input tb_req_t r);
    return r.tkt <= 4'd8;
  endfunction

  function automatic logic [15:0] eng_fare(input tb_req_t r);
    return 16'(r.tkt) * (r.train ? 16'd150 : 16'd100);
  endfunction

  function automatic tb_rsp_t expect_rsp(input int ctr, input tb_req_t r);
    tb_rsp_t e;
    e.ctr = 2'(ctr);
    if (!model_ok(r)) begin
      e.status = 2'b10; e.count = 4'd0; e.fare = 16'd0;
    end else if (eng_succ(r)) begin
      e.status = 2'b00; e.count = r.tkt; e.fare = eng_fare(r);
    end else begin
      e.status = 2'b01; e.count = 4'd0; e.fare = 16'd0;
    end
    return e;
  endfunction

  always @(posedge clk) cyc++;

  task automatic drive_inputs();
    req_valid = 2'b00;
    req_train_id = 2'b00; req_src = '0; req_dest = '0; req_tickets = '0;
    if (pend0.size() > 0) begin
      req_valid[0] = 1'b1; req_train_id[0] = pend0[0].train;
      req_src[2:0] = pend0[0].src; req_dest[2:0] = pend0[0].dest; req_tickets[3:0] = pend0[0].tkt;
    end
    if (pend1.size() > 0) begin
      req_valid[1] = 1'b1; req_train_id[1] = pend1[0].train;
      req_src[5:3] = pend1[0].src; req_dest[5:3] = pend1[0].dest; req_tickets[7:4] = pend1[0].tkt;
    end
  endtask

  // Driver: an accept seen mid-cycle completes at the next rising edge.
  initial begin : drv
    drive_inputs();
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (req_valid[0] && req_ready[0]) begin
          sb.push_back(expect_rsp(0, pend0[0]));
          if (model_ok(pend0[0])) book_q.push_back(pend0[0]);
          acc_log.push_back(0);
          void'(pend0.pop_front());
          n_acc++; last_acc_cyc = cyc;
        end else if (req_valid[0]) begin
          n_stall++;
        end
        if (req_valid[1] && req_ready[1]) begin
          sb.push_back(expect_rsp(1, pend1[0]));
          if (model_ok(pend1[0])) book_q.push_back(pend1[0]);
          acc_log.push_back(1);
          void'(pend1.pop_front());
          n_acc++; last_acc_cyc = cyc;
        end
      end
      @(posedge clk);
      #1;
      drive_inputs();
    end
  end

  // Engine: real results only in the sampling cycle, junk otherwise.
  initial begin
    eng_success = 1'b1; eng_booked_count = 4'hf; eng_total_fare = 16'hffff;
  end

  always @(negedge clk) begin
    if (rst) begin
      eng_since = 1000;
    end else if (eng_book_req) begin
      eng_since = 0;
      eng_op = {eng_train_id, eng_src, eng_dest, eng_num_tickets};
    end else if (eng_since < 1000) begin
      eng_since++;
    end
    if (eng_since == RESP_LAT) begin
      check("eng_hold", 32'({eng_train_id, eng_src, eng_dest, eng_num_tickets}), 32'(eng_op));
      if (eng_succ(eng_op)) begin
        eng_success = 1'b1; eng_booked_count = eng_op.tkt; eng_total_fare = eng_fare(eng_op);
      end else begin
        eng_success = 1'b0; eng_booked_count = 4'd7; eng_total_fare = 16'h1234;
      end
    end else begin
      eng_success = 1'b1; eng_booked_count = 4'hf; eng_total_fare = 16'hffff;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (rsp_valid) begin
        n_rsp++; last_rsp_cyc = cyc;
        if (sb.size() == 0) begin
          check("rsp_unexpected", 32'(1), 32'(0));
        end else begin
          mon_e = sb.pop_front();
          check("rsp_ctr",    32'(rsp_ctr),        32'(mon_e.ctr));
          check("rsp_status", 32'(rsp_status),     32'(mon_e.status));
          check("rsp_count",  32'(rsp_count),      32'(mon_e.count));
          check("rsp_fare",   32'(rsp_total_fare), 32'(mon_e.fare));
        end
      end
      if (eng_book_req) begin
        n_book++;
        check("book_consecutive", 32'(prev_book), 32'(0));
        prev_book_cyc = last_book_cyc; last_book_cyc = cyc;
        if (book_q.size() == 0) begin
          check("book_unexpected", 32'(1), 32'(0));
        end else begin
          mon_b = book_q.pop_front();
          check("eng_operands", 32'({eng_train_id, eng_src, eng_dest, eng_num_tickets}), 32'(mon_b));
        end
      end
      prev_book = eng_book_req;
    end else begin
      prev_book = 1'b0;
    end
  end

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((sb.size() != 0 || pend0.size() != 0 || pend1.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(n >= 3000), 32'(0));
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    sb.delete(); book_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin : main
    int b0, r0, n;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_rsp_valid", 32'(rsp_valid), 32'(0));
    check("reset_book_req",  32'(eng_book_req), 32'(0));
    check("reset_req_ready", 32'(req_ready), 32'(0));
    check("reset_stats",     32'({stat_served, stat_rejected}), 32'(0));
    check("reset_eng_ops",   32'({eng_src, eng_dest, eng_num_tickets}), 32'(0));
    rst = 1'b0;

    pend0.push_back(mk(1'b0, 3'd0, 3'd1, 4'd2));
    drain("t1_drain");
    check("t1_book_latency", 32'(last_book_cyc - last_acc_cyc), 32'(3));
    check("t1_rsp_latency",  32'(last_rsp_cyc - last_acc_cyc), 32'(4 + RESP_LAT));
    check("t1_book_count",   32'(n_book), 32'(1));
    check("t1_served",       32'(stat_served), 32'(1));

    do_reset();
    acc_log.delete(); b0 = n_book;
    pend0.push_back(mk(1'b0, 3'd0, 3'd2, 4'd3));
    pend1.push_back(mk(1'b1, 3'd1, 3'd3, 4'd5));
    drain("t2_drain");
    check("t2_accepts", 32'(acc_log.size()), 32'(2));
    check("t2_first_grant",  32'(acc_log.size() > 0 ? acc_log[0] : 9), 32'(0));
    check("t2_second_grant", 32'(acc_log.size() > 1 ? acc_log[1] : 9), 32'(1));
    check("t2_book_count", 32'(n_book - b0), 32'(2));
    check("t2_book_gap", 32'(last_book_cyc - prev_book_cyc), 32'(RESP_LAT + 4));

    b0 = n_book;
    pend1.push_back(mk(1'b1, 3'd2, 3'd2, 4'd3));
    drain("t3a_drain");
    check("t3_rejected_1", 32'(stat_rejected), 32'(1));
    check("t3_invalid_latency", 32'(last_rsp_cyc - last_acc_cyc), 32'(3));
    pend0.push_back(mk(1'b0, 3'd0, 3'd1, 4'd11));
    pend0.push_back(mk(1'b1, 3'd1, 3'd4, 4'd2));
    drain("t3b_drain");
    check("t3_no_book", 32'(n_book - b0), 32'(0));
    check("t3_rejected_3", 32'(stat_rejected), 32'(3));

    pend1.push_back(mk(1'b1, 3'd1, 3'd3, 4'd10));
    drain("t4_drain");
    check("t4_rejected", 32'(stat_rejected), 32'(4));
    check("t4_served", 32'(stat_served), 32'(2));

    n_stall = 0; r0 = n_rsp;
    for (int i = 0; i < 8; i++)
      pend0.push_back(mk(1'b0, 3'(i % 3), 3'd4, 4'(i + 2)));
    drain("t5_drain");
    check("t5_backpressure", 32'(n_stall > 0), 32'(1));
    check("t5_responses", 32'(n_rsp - r0), 32'(8));

    b0 = n_book;
    pend0.push_back(mk(1'b0, 3'd0, 3'd3, 4'd4));
    n = 0;
    while (n_book == b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t6_book_seen", 32'(n < 50), 32'(1));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("t6_rst_rsp_valid", 32'(rsp_valid), 32'(0));
    check("t6_rst_eng", 32'({eng_book_req, eng_train_id, eng_src, eng_dest, eng_num_tickets}), 32'(0));
    check("t6_rst_stats", 32'({stat_served, stat_rejected}), 32'(0));
    sb.delete(); book_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    r0 = n_rsp;
    repeat (15) @(negedge clk);
    check("t6_no_rsp", 32'(n_rsp - r0), 32'(0));
    pend1.push_back(mk(1'b1, 3'd0, 3'd3, 4'd5));
    drain("t6_drain");
    check("t6_recovered", 32'(n_rsp - r0), 32'(1));
    check("t6_served", 32'(stat_served), 32'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
